// File: rtl/mem_xfer_pkg.sv
// Shared types and channel assignments for the memory transfer sequencer.
package mem_xfer_pkg;

    typedef enum logic [1:0] {
        XS_IDLE = 2'd0,
        XS_RUN  = 2'd1,
        XS_TAIL = 2'd2
    } xfer_state_t;

    localparam int CH_WEIGHT = 0;
    localparam int CH_INPUT  = 1;
    localparam int CH_OUT_LD = 2;
    localparam int CH_OUT_WR = 3;

endpackage

// File: rtl/mem_xfer_channel.sv
// One transfer channel: index counter, optional write-tail drain, done pulse and sticky error.
//
// state   | meaning
// XS_IDLE | waiting for start; done pulses here for one cycle after completion
// XS_RUN  | idx addresses a live element, advances when en=1
// XS_TAIL | write pipeline draining, idx parked on last element
module mem_xfer_channel
    import mem_xfer_pkg::*;
#(
    parameter int IDX_W   = 6,
    parameter int TAIL_W  = 3,
    parameter int WR_TAIL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             en,
    input  logic             mode,
    input  logic [IDX_W-1:0] len,
    input  logic             clear_err,
    output logic             busy,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic             done,
    output logic             err
);

    localparam bit HAS_TAIL = (WR_TAIL > 0);

    xfer_state_t       state;
    logic [IDX_W-1:0]  len_q;
    logic              mode_q;
    logic [TAIL_W-1:0] tail_cnt;
    logic [IDX_W-1:0]  idx_last;

    // len_q is never zero outside IDLE, so this cannot underflow where it is used
    assign idx_last = len_q - IDX_W'(1);
    assign busy     = (state != XS_IDLE);
    assign valid    = (state == XS_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= XS_IDLE;
            idx      <= '0;
            len_q    <= '0;
            mode_q   <= 1'b0;
            tail_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (start && !abort && (state != XS_IDLE))
                err <= 1'b1;
            else if (clear_err)
                err <= 1'b0;

            case (state)
                XS_IDLE: begin
                    if (start && !abort) begin
                        len_q  <= len;
                        mode_q <= mode;
                        idx    <= '0;
                        if (len == '0)
                            done <= 1'b1;
                        else
                            state <= XS_RUN;
                    end
                end
                XS_RUN: begin
                    if (abort) begin
                        state <= XS_IDLE;
                        idx   <= '0;
                    end else if (en) begin
                        if (idx == idx_last) begin
                            if (mode_q && HAS_TAIL) begin
                                state    <= XS_TAIL;
                                tail_cnt <= TAIL_W'(WR_TAIL);
                            end else begin
                                state <= XS_IDLE;
                                idx   <= '0;
                                done  <= 1'b1;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                XS_TAIL: begin
                    if (abort) begin
                        state    <= XS_IDLE;
                        idx      <= '0;
                        tail_cnt <= '0;
                    end else if (en) begin
                        if (tail_cnt == TAIL_W'(1)) begin
                            state    <= XS_IDLE;
                            idx      <= '0;
                            tail_cnt <= '0;
                            done     <= 1'b1;
                        end else begin
                            tail_cnt <= tail_cnt - TAIL_W'(1);
                        end
                    end
                end
                default: begin
                    state <= XS_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_xfer_sequencer.sv
// Bank of independent transfer channels feeding idx/valid to the memory and file I/O blocks.
module mem_xfer_sequencer
    import mem_xfer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int IDX_W   = 6,
    parameter int TAIL_W  = 3,
    parameter int WR_TAIL = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*IDX_W-1:0] len,
    input  logic                    clear_err,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       valid,
    output logic [NUM_CH*IDX_W-1:0] idx,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       err
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mem_xfer_channel #(
            .IDX_W   (IDX_W),
            .TAIL_W  (TAIL_W),
            .WR_TAIL (WR_TAIL)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .abort     (abort[g]),
            .en        (en[g]),
            .mode      (mode[g]),
            .len       (len[g*IDX_W +: IDX_W]),
            .clear_err (clear_err),
            .busy      (busy[g]),
            .valid     (valid[g]),
            .idx       (idx[g*IDX_W +: IDX_W]),
            .done      (done[g]),
            .err       (err[g])
        );
    end

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Scoreboard bench: each accepted start queues the element stream and tail it should produce.
module tb_mem_xfer_sequencer;

    localparam int NUM_CH  = 4;
    localparam int IDX_W   = 6;
    localparam int TAIL_W  = 3;
    localparam int WR_TAIL = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH-1:0]       start = '0;
    logic [NUM_CH-1:0]       abort = '0;
    logic [NUM_CH-1:0]       en = '0;
    logic [NUM_CH-1:0]       mode = '0;
    logic [NUM_CH*IDX_W-1:0] len = '0;
    logic                    clear_err = 1'b0;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       valid;
    logic [NUM_CH*IDX_W-1:0] idx;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH-1:0]       err;

    mem_xfer_sequencer #(
        .NUM_CH  (NUM_CH),
        .IDX_W   (IDX_W),
        .TAIL_W  (TAIL_W),
        .WR_TAIL (WR_TAIL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .en        (en),
        .mode      (mode),
        .len       (len),
        .clear_err (clear_err),
        .busy      (busy),
        .valid     (valid),
        .idx       (idx),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: outstanding elements per channel, pending tail cycles, expected flags
    int exp_q [NUM_CH][$];
    int tail_rem  [NUM_CH];
    int tail_cur  [NUM_CH];
    int last_idx  [NUM_CH];
    bit start_cyc [NUM_CH];
    bit start_zero[NUM_CH];
    bit errset    [NUM_CH];
    bit err_m     [NUM_CH];
    bit done_due  [NUM_CH];
    bit mon_running;
    bit mon_nd;

    task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s ch%0d actual=%0d required=%0d at %0t", name, ch, act, req, $time);
        end
    endtask

    function automatic bit model_idle(input int ch);
        return (exp_q[ch].size() == 0) && (tail_rem[ch] == 0);
    endfunction

    function automatic logic [NUM_CH*IDX_W-1:0] pack_len(input int l0, input int l1, input int l2, input int l3);
        logic [NUM_CH*IDX_W-1:0] v;
        v = {IDX_W'(l3), IDX_W'(l2), IDX_W'(l1), IDX_W'(l0)};
        return v;
    endfunction

    // called just after a rising edge; applies inputs for one cycle
    task automatic step(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] e,
                        input logic [NUM_CH-1:0] m, input logic [NUM_CH*IDX_W-1:0] l, input logic clr);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit idle;
            int ln;
            idle = model_idle(ch);
            ln = int'(l[ch*IDX_W +: IDX_W]);
            errset[ch] = s[ch] && !a[ch] && !idle;
            if (s[ch] && !a[ch] && idle) begin
                start_cyc[ch] = 1'b1;
                start_zero[ch] = (ln == 0);
                for (int i = 0; i < ln; i++) exp_q[ch].push_back(i);
                last_idx[ch] = ln - 1;
                tail_cur[ch] = m[ch] ? WR_TAIL : 0;
            end
        end
        start = s; abort = a; en = e; mode = m; len = l; clear_err = clr;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            start_cyc[ch] = 1'b0;
            start_zero[ch] = 1'b0;
            errset[ch] = 1'b0;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '1, '0, '0, 1'b0);
    endtask

    task automatic check_all_zero(input string name);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check({name, "_busy"}, ch, busy[ch], 0);
            check({name, "_valid"}, ch, valid[ch], 0);
            check({name, "_idx"}, ch, idx[ch*IDX_W +: IDX_W], 0);
            check({name, "_done"}, ch, done[ch], 0);
            check({name, "_err"}, ch, err[ch], 0);
        end
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        start = '0; abort = '0; en = '0; mode = '0; len = '0; clear_err = 1'b0;
        #1;
        check_all_zero("reset_async");
        for (int ch = 0; ch < NUM_CH; ch++) begin
            exp_q[ch].delete();
            tail_rem[ch] = 0;
            done_due[ch] = 1'b0;
            err_m[ch] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mon_running = (exp_q[ch].size() > 0) && !start_cyc[ch];
                check("done", ch, done[ch], done_due[ch]);
                check("err", ch, err[ch], err_m[ch]);
                if (mon_running) begin
                    check("run_busy", ch, busy[ch], 1);
                    check("run_valid", ch, valid[ch], 1);
                    check("run_idx", ch, idx[ch*IDX_W +: IDX_W], exp_q[ch][0]);
                end else if (tail_rem[ch] > 0) begin
                    check("tail_busy", ch, busy[ch], 1);
                    check("tail_valid", ch, valid[ch], 0);
                    check("tail_idx", ch, idx[ch*IDX_W +: IDX_W], last_idx[ch]);
                end else begin
                    check("idle_busy", ch, busy[ch], 0);
                    check("idle_valid", ch, valid[ch], 0);
                    check("idle_idx", ch, idx[ch*IDX_W +: IDX_W], 0);
                end
                mon_nd = 1'b0;
                if (abort[ch] && (mon_running || tail_rem[ch] > 0)) begin
                    exp_q[ch].delete();
                    tail_rem[ch] = 0;
                end else if (mon_running && en[ch]) begin
                    void'(exp_q[ch].pop_front());
                    if (exp_q[ch].size() == 0) begin
                        if (tail_cur[ch] > 0) tail_rem[ch] = tail_cur[ch];
                        else mon_nd = 1'b1;
                    end
                end else if (tail_rem[ch] > 0 && en[ch]) begin
                    tail_rem[ch]--;
                    if (tail_rem[ch] == 0) mon_nd = 1'b1;
                end
                if (start_cyc[ch] && start_zero[ch]) mon_nd = 1'b1;
                done_due[ch] = mon_nd;
                if (errset[ch]) err_m[ch] = 1'b1;
                else if (clear_err) err_m[ch] = 1'b0;
            end
        end
    end

    initial begin
        logic [NUM_CH-1:0] rs, ra, re, rm;
        logic [NUM_CH*IDX_W-1:0] rl;
        logic rc;
        bit all_idle;

        for (int ch = 0; ch < NUM_CH; ch++) begin
            tail_rem[ch] = 0; tail_cur[ch] = 0; last_idx[ch] = 0;
            start_cyc[ch] = 0; start_zero[ch] = 0; errset[ch] = 0; err_m[ch] = 0; done_due[ch] = 0;
        end

        #2;
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset in the middle of a run: ch0 at idx=2
        step(4'b0001, '0, '1, '0, pack_len(4, 0, 0, 0), 1'b0);
        idle_steps(2);
        do_reset();
        idle_steps(6);

        // basic load on ch0
        step(4'b0001, '0, '1, '0, pack_len(4, 0, 0, 0), 1'b0);
        idle_steps(6);

        // write with tail on ch3
        step(4'b1000, '0, '1, 4'b1000, pack_len(0, 0, 0, 8), 1'b0);
        idle_steps(12);

        // stall ch1 at idx=1 for two cycles
        step(4'b0010, '0, '1, '0, pack_len(0, 3, 0, 0), 1'b0);
        step('0, '0, '1, '0, '0, 1'b0);
        step('0, '0, 4'b1101, '0, '0, 1'b0);
        step('0, '0, 4'b1101, '0, '0, 1'b0);
        idle_steps(5);

        // start while busy on ch2 sets sticky err, then clear it
        step(4'b0100, '0, '1, '0, pack_len(0, 0, 5, 0), 1'b0);
        idle_steps(2);
        step(4'b0100, '0, '1, '0, pack_len(0, 0, 7, 0), 1'b0);
        idle_steps(8);
        step('0, '0, '1, '0, '0, 1'b1);
        idle_steps(2);

        // zero length on ch2
        step(4'b0100, '0, '1, '0, '0, 1'b0);
        idle_steps(3);

        // abort together with start on a busy ch0
        step(4'b0001, '0, '1, '0, pack_len(6, 0, 0, 0), 1'b0);
        idle_steps(2);
        step(4'b0001, 4'b0001, '1, '0, pack_len(6, 0, 0, 0), 1'b0);
        idle_steps(4);

        // all channels at once, lengths 1..4
        step(4'b1111, '0, '1, '0, pack_len(1, 2, 3, 4), 1'b0);
        idle_steps(7);

        // back-to-back on ch0: restart in the done cycle
        step(4'b0001, '0, '1, '0, pack_len(2, 0, 0, 0), 1'b0);
        idle_steps(2);
        step(4'b0001, '0, '1, 4'b0001, pack_len(3, 0, 0, 0), 1'b0);
        idle_steps(8);

        // maximum length with tail on ch1
        step(4'b0010, '0, '1, 4'b0010, pack_len(0, 63, 0, 0), 1'b0);
        idle_steps(70);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rs = '0; ra = '0; re = '0; rm = '0; rl = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rs[ch] = ($urandom_range(0, 5) == 0);
                ra[ch] = ($urandom_range(0, 39) == 0);
                re[ch] = ($urandom_range(0, 3) != 0);
                rm[ch] = $urandom_range(0, 1) == 1;
                rl[ch*IDX_W +: IDX_W] = ($urandom_range(0, 19) == 0) ? IDX_W'(63) : IDX_W'($urandom_range(0, 9));
            end
            rc = ($urandom_range(0, 29) == 0);
            step(rs, ra, re, rm, rl, rc);
        end

        all_idle = 1'b0;
        for (int n = 0; n < 200 && !all_idle; n++) begin
            idle_steps(1);
            all_idle = 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++)
                if (!model_idle(ch)) all_idle = 1'b0;
        end
        checks++;
        if (!all_idle) begin
            failures++;
            $display("FAIL drain actual=busy required=idle within 200 cycles");
        end
        idle_steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_xfer_sequencer.md
Name: mem_xfer_sequencer

Overview:
- Parametrised successor to the per-memory load/write flag generator.
- Drives NUM_CH independent file-transfer channels, for example weight load, input load, output load and output write.
- Each channel owns its own index counter, runtime length, stall input, optional write-tail phase, abort and done/error reporting.
- Sits between the top-level test controller and the memory/file I/O blocks; downstream blocks consume idx/valid instead of maintaining their own counters.

Parameters:
- NUM_CH, 4: number of independent transfer channels.
- IDX_W, 6: index/length width; the maximum length per transfer is 2^IDX_W-1.
- TAIL_W, 3: width of the tail-cycle count.
- WR_TAIL, 2: extra cycles held busy after the last index on channels with mode=1, covering pipeline drain before the file write closes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  NUM_CH  per-channel start pulse.
- abort  in  NUM_CH  per-channel abort pulse.
- en  in  NUM_CH  per-channel advance enable; 0 stalls the channel.
- mode  in  NUM_CH  per-channel mode: 0 = load (no tail), 1 = write (WR_TAIL tail); sampled at start.
- len  in  NUM_CH*IDX_W  per-channel transfer length, packed with channel i at [i*IDX_W +: IDX_W]; sampled at start.
- clear_err  in  1  clears all sticky error bits.
- busy  out  NUM_CH  channel is in RUN or TAIL.
- valid  out  NUM_CH  channel is in RUN, so idx addresses a live element.
- idx  out  NUM_CH*IDX_W  per-channel current index, packed like len.
- done  out  NUM_CH  one-cycle completion pulse.
- err  out  NUM_CH  sticky flag: start received while the channel was busy.

Behaviour:
- Reset: asynchronous, active-low. Every channel goes to IDLE; busy, valid, done and err = 0; idx = 0; latched len/mode = 0; tail counter = 0. Reset mid-transfer discards the transfer with no done pulse.
- Channel state machine, one per channel:
  - IDLE: on start (and not abort), latch len and mode, set idx = 0. If len = 0, stay in IDLE and pulse done on the next cycle. Otherwise go to RUN; busy and valid assert on the cycle after start (one-cycle latency).
  - RUN: if en=1 and idx < len_q-1, idx increments. If en=1 and idx = len_q-1: go to TAIL with tail counter = WR_TAIL when mode_q=1 and WR_TAIL>0; otherwise go to IDLE and pulse done. If en=0, idx holds.
  - TAIL: valid=0, busy=1, idx holds at len_q-1. The tail counter decrements only when en=1. When the counter reaches 1 with en=1, go to IDLE and pulse done.
- done:
  - Asserts for exactly one cycle, the first IDLE cycle after completion (registered).
  - idx returns to 0 in that same cycle.
- Back-to-back transfers: start may be asserted in the same cycle done is high, since the channel is already IDLE. The new transfer runs with no bubble beyond the start latency.
- start while busy:
  - Ignored; the transfer continues unaffected.
  - err[i] sets and stays set until clear_err.
  - If clear_err and the setting event occur in the same cycle, set wins.
- abort:
  - Any state goes to IDLE next cycle: idx = 0, busy = valid = 0, no done.
  - abort has priority over start and over completion in the same cycle.
  - abort while IDLE has no effect.
- Timing and independence:
  - Channels are fully independent; simultaneous starts on all channels are legal.
  - Transfer time with en held high = len cycles in RUN plus WR_TAIL cycles in TAIL (mode=1 only), then done.
- Width rules:
  - idx is compared against len_q-1 at IDX_W bits; len_q = 0 never enters RUN, so no underflow occurs.
  - len = 2^IDX_W-1 must complete without idx wrap.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package mem_xfer_pkg:
  - State enum xfer_state_t = {XS_IDLE, XS_RUN, XS_TAIL}, 2 bits.
  - Default localparams for channel indices: CH_WEIGHT=0, CH_INPUT=1, CH_OUT_LD=2, CH_OUT_WR=3.
- Sub-module mem_xfer_channel:
  - One instance per channel, holding the state machine, idx and tail counters, and the err bit.
  - The top level is a generate loop plus port packing.

Test Plan:
- Reset mid-RUN: ch0 len=4 mode=0, assert rst_n=0 at idx=2 -> all outputs 0 immediately, no done after release.
- Basic load: ch0 start, len=4, mode=0, en=1 -> busy/valid high for 4 cycles with idx 0,1,2,3; done pulses one cycle later; idx=0.
- Write tail: ch3 len=8, mode=1, WR_TAIL=2 -> valid for 8 cycles (idx 0..7), then 2 cycles busy & !valid with idx=7, then done.
- Stall: ch1 len=3, en low for 2 cycles at idx=1 -> idx holds at 1; total busy = 5 cycles; done once.
- Errors and zero length, on ch2:
  - start at idx=2 during len=5 -> transfer unaffected, err[2]=1 sticky until clear_err.
  - len=0 start -> no busy; done pulses the next cycle.
- Abort and concurrency:
  - abort+start together on busy ch0 -> IDLE next cycle, no done, err unchanged.
  - All 4 channels started together with len 1,2,3,4 -> independent done pulses at cycles 2,3,4,5 after start.
